// File: rtl/acc_pkg.sv
// Shared defaults and FSM state encoding for the matrix-vector sequencer.
package acc_pkg;
  localparam int DEFAULT_PE_NUMBER = 64;
  localparam int DEFAULT_ADDR_SIZE = 16;
  localparam int DEFAULT_WORD_SIZE = 32;

  // Value every base/address register returns to on reset.
  localparam logic [DEFAULT_ADDR_SIZE-1:0] ZERO_POINT_ADDR = '0;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_VEC,
    STREAM,
    DRAIN,
    WRITE
  } state_t;
endpackage

// File: rtl/matvec_sequencer_if.sv
// Memory and systolic-array side of the sequencer: read/write ports plus element stream.
interface matvec_sequencer_if
  import acc_pkg::*;
#(
  parameter int PE_NUMBER = DEFAULT_PE_NUMBER,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
  logic                         r_en;
  logic [ADDR_SIZE-1:0]         r_addr;
  logic [WORD_SIZE-1:0]         r_data;
  logic                         w_en;
  logic [ADDR_SIZE-1:0]         w_addr;
  logic [WORD_SIZE-1:0]         w_data;
  logic                         arr_reset;
  logic                         pe_load;
  logic                         feed_valid;
  logic [WORD_SIZE-1:0]         feed_data;
  logic [$clog2(PE_NUMBER)-1:0] feed_idx;
  logic                         res_valid;
  logic [WORD_SIZE-1:0]         res_data;

  modport master (
    output r_en, r_addr, w_en, w_addr, w_data,
    output arr_reset, pe_load, feed_valid, feed_data, feed_idx,
    input  r_data, res_valid, res_data
  );

  modport slave (
    input  r_en, r_addr, w_en, w_addr, w_data,
    input  arr_reset, pe_load, feed_valid, feed_data, feed_idx,
    output r_data, res_valid, res_data
  );
endinterface

// File: rtl/seq_addr_gen.sv
// Walks PE_NUMBER consecutive read addresses from base + row*PE_NUMBER and delays the
// strobe/index by one cycle so they line up with the returning memory data.
module seq_addr_gen
  import acc_pkg::*;
#(
  parameter int PE_NUMBER = DEFAULT_PE_NUMBER,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [ADDR_SIZE-1:0]         base,
  input  logic [7:0]                   row,
  output logic                         r_en,
  output logic [ADDR_SIZE-1:0]         r_addr,
  output logic                         last,
  output logic                         dly_valid,
  output logic [$clog2(PE_NUMBER)-1:0] dly_idx
);
  localparam int IDX_W = $clog2(PE_NUMBER);
  localparam logic [ADDR_SIZE-1:0] ROW_STRIDE = ADDR_SIZE'(PE_NUMBER);
  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0]   cnt_reg;
  logic             dly_valid_reg;
  logic [IDX_W-1:0] dly_idx_reg;

  // Count == PE_NUMBER is the cycle carrying the final delayed element.
  assign r_en      = run && !cnt_reg[IDX_W];
  assign last      = run && cnt_reg[IDX_W];
  assign r_addr    = r_en ? (base + ADDR_SIZE'(row) * ROW_STRIDE + ADDR_SIZE'(cnt_reg)) : '0;
  assign dly_valid = dly_valid_reg;
  assign dly_idx   = dly_idx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      dly_valid_reg <= 1'b0;
      dly_idx_reg   <= '0;
    end else begin
      cnt_reg       <= r_en ? cnt_reg + CNT_ONE : '0;
      dly_valid_reg <= r_en;
      if (r_en) begin
        dly_idx_reg <= cnt_reg[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/matvec_sequencer.sv
// Job sequencer for a systolic matrix-vector unit: loads the vector as PE weights,
// streams each matrix row, waits for the row result and writes it back to memory.
module matvec_sequencer
  import acc_pkg::*;
#(
  parameter int PE_NUMBER = DEFAULT_PE_NUMBER,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_SIZE-1:0] vec_base,
  input  logic [ADDR_SIZE-1:0] mat_base,
  input  logic [ADDR_SIZE-1:0] out_base,
  input  logic [7:0]           rows,
  output logic                 busy,
  output logic                 done,
  matvec_sequencer_if.master   bus
);
  localparam int IDX_W = $clog2(PE_NUMBER);

  state_t               state_reg, state_next;
  logic [ADDR_SIZE-1:0] vec_base_reg, mat_base_reg, out_base_reg;
  logic [7:0]           rows_reg, row_reg;
  logic [WORD_SIZE-1:0] result_reg;
  logic                 done_reg, abort_pulse_reg;
  logic                 accept, kill, last_row, w_en_c;
  logic                 gen_run, gen_last, dly_valid;
  logic [ADDR_SIZE-1:0] gen_base;
  logic [7:0]           gen_row;
  logic [IDX_W-1:0]     dly_idx;

  assign accept   = (state_reg == IDLE) && start;
  assign kill     = (state_reg != IDLE) && abort;
  assign last_row = ({1'b0, row_reg} + 9'd1) == {1'b0, rows_reg};
  // Gating the generator with kill stops reads in the abort cycle itself.
  assign gen_run  = ((state_reg == LOAD_VEC) || (state_reg == STREAM)) && !kill;
  assign gen_base = (state_reg == STREAM) ? mat_base_reg : vec_base_reg;
  assign gen_row  = (state_reg == STREAM) ? row_reg : 8'd0;

  seq_addr_gen #(
    .PE_NUMBER (PE_NUMBER),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (gen_run),
    .base      (gen_base),
    .row       (gen_row),
    .r_en      (bus.r_en),
    .r_addr    (bus.r_addr),
    .last      (gen_last),
    .dly_valid (dly_valid),
    .dly_idx   (dly_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:     if (start && (rows != 8'd0)) state_next = CLEAR;
        CLEAR:    state_next = LOAD_VEC;
        LOAD_VEC: if (gen_last) state_next = STREAM;
        STREAM:   if (gen_last) state_next = DRAIN;
        DRAIN:    if (bus.res_valid) state_next = WRITE;
        WRITE:    state_next = last_row ? IDLE : STREAM;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_en_c         = (state_reg == WRITE) && !kill;
    busy           = (state_reg != IDLE);
    done           = done_reg;
    bus.arr_reset  = (state_reg == CLEAR) || abort_pulse_reg;
    bus.pe_load    = dly_valid && (state_reg == LOAD_VEC);
    bus.feed_valid = dly_valid && (state_reg == STREAM);
    bus.feed_data  = dly_valid ? bus.r_data : '0;
    bus.feed_idx   = dly_idx;
    bus.w_en       = w_en_c;
    bus.w_addr     = w_en_c ? (out_base_reg + ADDR_SIZE'(row_reg)) : '0;
    bus.w_data     = w_en_c ? result_reg : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_base_reg    <= ADDR_SIZE'(ZERO_POINT_ADDR);
      mat_base_reg    <= ADDR_SIZE'(ZERO_POINT_ADDR);
      out_base_reg    <= ADDR_SIZE'(ZERO_POINT_ADDR);
      rows_reg        <= '0;
      row_reg         <= '0;
      result_reg      <= '0;
      done_reg        <= 1'b0;
      abort_pulse_reg <= 1'b0;
    end else begin
      done_reg        <= 1'b0;
      abort_pulse_reg <= kill;
      if (accept) begin
        vec_base_reg <= vec_base;
        mat_base_reg <= mat_base;
        out_base_reg <= out_base;
        rows_reg     <= rows;
        row_reg      <= '0;
        done_reg     <= (rows == 8'd0);
      end
      if ((state_reg == DRAIN) && bus.res_valid && !kill) begin
        result_reg <= bus.res_data;
      end
      if ((state_reg == WRITE) && !kill) begin
        if (last_row) begin
          done_reg <= 1'b1;
        end else begin
          row_reg <= row_reg + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: memory model returns {~addr, addr}, the bench plays
// the array by returning a row result, and job-level counts/writes are checked afterwards.
module tb_matvec_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] vec_base, mat_base, out_base;
  logic [7:0]  rows;
  logic        busy, done;

  matvec_sequencer_if #(.PE_NUMBER(64), .ADDR_SIZE(16), .WORD_SIZE(32)) bus ();

  matvec_sequencer #(.PE_NUMBER(64), .ADDR_SIZE(16), .WORD_SIZE(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .vec_base (vec_base),
    .mat_base (mat_base),
    .out_base (out_base),
    .rows     (rows),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [15:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (bus.r_en) bus.r_data <= memval(bus.r_addr);
  end

  // Monitor: cumulative event counters, per-element data checks, write log.
  int n_ren = 0, n_load = 0, n_feed = 0, n_wen = 0, n_done = 0, n_arr = 0, n_low = 0;
  int ld_bad = 0, fd_bad = 0, ld_idx = 0, fd_idx = 0, fd_row = 0;
  logic [15:0] cur_vec = '0, cur_mat = '0;
  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];

  always @(negedge clk) begin : mon
    logic [15:0] ea;
    if (bus.arr_reset) begin
      n_arr++;
      ld_idx = 0; fd_idx = 0; fd_row = 0;
    end
    if (bus.r_en) begin
      n_ren++;
      if (bus.r_addr < 16'h0040) n_low++;
    end
    if (bus.pe_load) begin
      n_load++;
      ea = cur_vec + 16'(ld_idx);
      if (bus.feed_idx != 6'(ld_idx) || bus.feed_data != memval(ea)) ld_bad++;
      ld_idx++;
    end
    if (bus.feed_valid) begin
      n_feed++;
      ea = cur_mat + 16'(fd_row * 64 + fd_idx);
      if (bus.feed_idx != 6'(fd_idx) || bus.feed_data != memval(ea)) fd_bad++;
      fd_idx++;
      if (fd_idx == 64) begin fd_idx = 0; fd_row++; end
    end
    if (bus.w_en) begin
      n_wen++;
      wq_addr.push_back(bus.w_addr);
      wq_data.push_back(bus.w_data);
    end
    if (done) n_done++;
  end

  int n_checks = 0, n_fail = 0;
  int s_ren, s_load, s_feed, s_wen, s_done, s_arr, s_low, s_ldb, s_fdb, s_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_ren = n_ren; s_load = n_load; s_feed = n_feed; s_wen = n_wen; s_done = n_done;
    s_arr = n_arr; s_low = n_low; s_ldb = ld_bad; s_fdb = fd_bad; s_w = wq_addr.size();
  endtask

  function automatic logic [31:0] wa(input int i);
    return (i < wq_addr.size()) ? 32'(wq_addr[i]) : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return (i < wq_data.size()) ? wq_data[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic start_job(input logic [15:0] vb, mb, ob, input logic [7:0] rw);
    vec_base = vb; mat_base = mb; out_base = ob; rows = rw;
    cur_vec = vb; cur_mat = mb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_feed(input string tag, input int target);
    int g = 0;
    while ((n_feed - s_feed) < target && g < 2000) begin tick(); g++; end
    chk({tag, "_feed_timeout"}, 32'(g >= 2000), 0);
  endtask

  // Play the array: result arrives a few cycles into DRAIN; returns in the WRITE cycle.
  task automatic serve_row(input string tag, input int r);
    wait_feed(tag, 64 * (r + 1));
    tick(); tick();
    bus.res_valid = 1'b1;
    bus.res_data  = 32'h5EED_0000 | 32'(r);
    tick();
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while ((n_done - s_done) < 1 && g < 50) begin tick(); g++; end
    chk({tag, "_done_timeout"}, 32'(g >= 50), 0);
    tick(); tick();
    chk({tag, "_busy_after_done"}, 32'(busy), 0);
  endtask

  task automatic check_job(input string tag, input int e_ren, e_load, e_feed, e_wen, e_done);
    chk({tag, "_r_en_count"}, n_ren - s_ren, e_ren);
    chk({tag, "_pe_load_count"}, n_load - s_load, e_load);
    chk({tag, "_feed_count"}, n_feed - s_feed, e_feed);
    chk({tag, "_w_en_count"}, n_wen - s_wen, e_wen);
    chk({tag, "_done_count"}, n_done - s_done, e_done);
    chk({tag, "_load_data_errs"}, ld_bad - s_ldb, 0);
    chk({tag, "_feed_data_errs"}, fd_bad - s_fdb, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rows = '0;
    vec_base = '0; mat_base = '0; out_base = '0;
    bus.res_valid = 1'b0; bus.res_data = '0;
    repeat (3) tick();
    chk("rst_strobes", 32'({busy, done, bus.r_en, bus.pe_load, bus.feed_valid, bus.w_en, bus.arr_reset}), 0);
    chk("rst_r_addr", 32'(bus.r_addr), 0);
    chk("rst_w_addr", 32'(bus.w_addr), 0);
    chk("rst_w_data", bus.w_data, 0);
    chk("rst_feed_idx", 32'(bus.feed_idx), 0);
    chk("rst_feed_data", bus.feed_data, 0);
    reset = 1'b0;
    tick();

    // Job A: rows=2, with an ignored start and a stray res_valid while streaming.
    snap();
    start_job(16'h0000, 16'h0100, 16'h0200, 8'd2);
    chk("A_busy", 32'(busy), 1);
    chk("A_clear_arr_reset", 32'(bus.arr_reset), 1);
    chk("A_clear_r_en", 32'(bus.r_en), 0);
    tick();
    chk("A_ld0_r_en", 32'(bus.r_en), 1);
    chk("A_ld0_r_addr", 32'(bus.r_addr), 32'h0000);
    chk("A_ld0_pe_load", 32'(bus.pe_load), 0);
    chk("A_ld0_arr_reset", 32'(bus.arr_reset), 0);
    tick();
    chk("A_ld1_r_addr", 32'(bus.r_addr), 32'h0001);
    chk("A_ld1_pe_load", 32'(bus.pe_load), 1);
    chk("A_ld1_feed_data", bus.feed_data, 32'hFFFF_0000);
    wait_feed("A_noise", 20);
    start = 1'b1; rows = 8'd5; vec_base = 16'h0900; mat_base = 16'h0800; out_base = 16'h0300;
    bus.res_valid = 1'b1; bus.res_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
    serve_row("A0", 0);
    serve_row("A1", 1);
    wait_done("A");
    check_job("A", 192, 64, 128, 2, 1);
    chk("A_arr_reset_count", n_arr - s_arr, 1);
    chk("A_w0_addr", wa(s_w), 32'h0200);
    chk("A_w0_data", wd(s_w), 32'h5EED_0000);
    chk("A_w1_addr", wa(s_w + 1), 32'h0201);
    chk("A_w1_data", wd(s_w + 1), 32'h5EED_0001);

    // Job B: rows=0 completes immediately without any activity.
    snap();
    start_job(16'h1234, 16'h2345, 16'h3456, 8'd0);
    chk("B_done_pulse", 32'(done), 1);
    chk("B_busy", 32'(busy), 0);
    tick();
    chk("B_done_low", 32'(done), 0);
    repeat (3) tick();
    chk("B_r_en_count", n_ren - s_ren, 0);
    chk("B_w_en_count", n_wen - s_wen, 0);
    chk("B_arr_reset_count", n_arr - s_arr, 0);
    chk("B_done_count", n_done - s_done, 1);

    // Job C: abort partway through row 1 of 3.
    snap();
    start_job(16'h0040, 16'h1000, 16'h0500, 8'd3);
    serve_row("C0", 0);
    wait_feed("C1", 74);
    s_ren = n_ren; s_wen = n_wen;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("C_idle_after_abort", 32'(busy), 0);
    chk("C_abort_arr_reset", 32'(bus.arr_reset), 1);
    chk("C_abort_r_en", 32'(bus.r_en), 0);
    tick();
    chk("C_arr_reset_one_cycle", 32'(bus.arr_reset), 0);
    bus.res_valid = 1'b1; bus.res_data = 32'h0BAD_0BAD;
    tick();
    bus.res_valid = 1'b0; bus.res_data = '0;
    repeat (100) tick();
    chk("C_r_en_after_abort", n_ren - s_ren, 0);
    chk("C_w_en_after_abort", n_wen - s_wen, 0);
    chk("C_done_count", n_done - s_done, 0);
    chk("C_write_count", wq_addr.size() - s_w, 1);
    chk("C_w0_addr", wa(s_w), 32'h0500);
    chk("C_w0_data", wd(s_w), 32'h5EED_0000);
    chk("C_feed_data_errs", fd_bad - s_fdb, 0);

    // Job D: matrix and output addresses wrap around the top of memory.
    snap();
    start_job(16'h0080, 16'hFFC0, 16'hFFFF, 8'd2);
    serve_row("D0", 0);
    serve_row("D1", 1);
    wait_done("D");
    check_job("D", 192, 64, 128, 2, 1);
    chk("D_wrapped_reads", n_low - s_low, 64);
    chk("D_w0_addr", wa(s_w), 32'hFFFF);
    chk("D_w0_data", wd(s_w), 32'h5EED_0000);
    chk("D_w1_addr", wa(s_w + 1), 32'h0000);
    chk("D_w1_data", wd(s_w + 1), 32'h5EED_0001);

    // Job E: reset while waiting for the row result.
    snap();
    start_job(16'h0010, 16'h0200, 16'h0300, 8'd1);
    wait_feed("E", 64);
    tick();
    chk("E_in_drain_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("E_rst_strobes", 32'({busy, done, bus.r_en, bus.pe_load, bus.feed_valid, bus.w_en, bus.arr_reset}), 0);
    chk("E_rst_feed_idx", 32'(bus.feed_idx), 0);
    chk("E_rst_w_addr", 32'(bus.w_addr), 0);
    repeat (3) tick();
    reset = 1'b0;
    bus.res_valid = 1'b1; bus.res_data = 32'h0BAD_F00D;
    tick();
    bus.res_valid = 1'b0; bus.res_data = '0;
    repeat (20) tick();
    chk("E_done_after_reset", n_done - s_done, 0);
    chk("E_w_en_after_reset", n_wen - s_wen, 0);

    // Job F: clean single-row job after the reset.
    snap();
    start_job(16'h0000, 16'h0400, 16'h0700, 8'd1);
    serve_row("F0", 0);
    wait_done("F");
    check_job("F", 128, 64, 64, 1, 1);
    chk("F_w0_addr", wa(s_w), 32'h0700);
    chk("F_w0_data", wd(s_w), 32'h5EED_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
